// File: rtl/gpio_pkg.sv
// gpio_bank shared definitions: register offsets, data width,
// and the width of the post-reset edge-priming counter.
package gpio_pkg;

  localparam int DATA_W  = 32;
  localparam int PRIME_W = 2;

  localparam logic [31:0] GPIO_OE         = 32'h00;
  localparam logic [31:0] GPIO_OUT        = 32'h04;
  localparam logic [31:0] GPIO_IN         = 32'h08;
  localparam logic [31:0] GPIO_SET        = 32'h0C;
  localparam logic [31:0] GPIO_CLR        = 32'h10;
  localparam logic [31:0] GPIO_TGL        = 32'h14;
  localparam logic [31:0] GPIO_IRQ_EN     = 32'h18;
  localparam logic [31:0] GPIO_IRQ_RISE   = 32'h1C;
  localparam logic [31:0] GPIO_IRQ_FALL   = 32'h20;
  localparam logic [31:0] GPIO_IRQ_STATUS = 32'h24;

endpackage

// File: rtl/gpio_if.sv
// Register-port bundle for gpio_bank: single request,
// one-cycle ready acknowledge with read data.
interface gpio_if #(
  parameter int ADDR_W = 6
) ();
  import gpio_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/gpio_sync.sv
// N-bit multi-stage input synchronizer with a trailing
// "previous" flop for edge detection.
module gpio_sync #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] sync_o,
  output logic [N-1:0] prev_o
);

  logic [STAGES-1:0][N-1:0] stg_q;
  logic [N-1:0]             prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_q  <= '0;
      prev_q <= '0;
    end else begin
      stg_q  <= {stg_q[STAGES-2:0], d_i};
      prev_q <= stg_q[STAGES-1];
    end
  end

  assign sync_o = stg_q[STAGES-1];
  assign prev_o = prev_q;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO controller: register port, atomic
// set/clear/toggle, synchronised inputs, edge interrupts.
module gpio_bank import gpio_pkg::*; #(
  parameter int N_GPIO      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  gpio_if.slave             bus,
  input  logic [N_GPIO-1:0] gpio_val_i,
  output logic [N_GPIO-1:0] gpio_val_o,
  output logic [N_GPIO-1:0] gpio_dir_o,
  output logic              irq_o
);

  localparam int PCNT = SYNC_STAGES + 1;
  localparam int PW   =
    (PCNT > 3) ? $clog2(PCNT + 1) : PRIME_W;

  logic [N_GPIO-1:0] oe_q, oe_d;
  logic [N_GPIO-1:0] out_q, out_d;
  logic [N_GPIO-1:0] en_q, en_d;
  logic [N_GPIO-1:0] rise_q, rise_d;
  logic [N_GPIO-1:0] fall_q, fall_d;
  logic [N_GPIO-1:0] stat_q, stat_d;
  logic [PW-1:0]     prime_q, prime_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [N_GPIO-1:0] sync, prev, edges, w1c, wd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       off;
  logic [DATA_W-1:0] rd;
  logic              accept, wr, primed;
  logic              unused_bits;

  assign addr        = bus.addr;
  assign off         = 32'(addr) & 32'hFFFF_FFFC;
  assign wd          = bus.wdata[N_GPIO-1:0];
  assign unused_bits = ^bus.wdata;
  assign accept      = bus.req & ~ready_q;
  assign wr          = accept & bus.we;

  gpio_sync #(
    .N      (N_GPIO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (sys_clk_i),
    .rst_i  (sys_rst_i),
    .d_i    (gpio_val_i),
    .sync_o (sync),
    .prev_o (prev)
  );

  // Flops are still filling right after reset; ignore edges until settled.
  assign primed  = (prime_q == PW'(PCNT));
  assign prime_d = primed ? prime_q : prime_q + 1'b1;

  assign edges = (sync & ~prev & rise_q) |
                 (~sync & prev & fall_q);

  always_comb begin
    rd = '0;
    case (off)
      GPIO_OE:         rd = DATA_W'(oe_q);
      GPIO_OUT:        rd = DATA_W'(out_q);
      GPIO_IN:         rd = DATA_W'(sync);
      GPIO_IRQ_EN:     rd = DATA_W'(en_q);
      GPIO_IRQ_RISE:   rd = DATA_W'(rise_q);
      GPIO_IRQ_FALL:   rd = DATA_W'(fall_q);
      GPIO_IRQ_STATUS: rd = DATA_W'(stat_q);
      default:         rd = '0;
    endcase
  end

  always_comb begin
    oe_d   = oe_q;
    out_d  = out_q;
    en_d   = en_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr) begin
      case (off)
        GPIO_OE:         oe_d   = wd;
        GPIO_OUT:        out_d  = wd;
        GPIO_SET:        out_d  = out_q | wd;
        GPIO_CLR:        out_d  = out_q & ~wd;
        GPIO_TGL:        out_d  = out_q ^ wd;
        GPIO_IRQ_EN:     en_d   = wd;
        GPIO_IRQ_RISE:   rise_d = wd;
        GPIO_IRQ_FALL:   fall_d = wd;
        GPIO_IRQ_STATUS: w1c    = wd;
        default:         ;
      endcase
    end
  end

  // A fresh edge beats a same-cycle W1C on the same bit.
  assign stat_d  = (stat_q & ~w1c) |
                   (primed ? edges : '0);
  assign ready_d = accept;
  assign rdata_d = (accept & ~bus.we) ? rd : '0;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      oe_q    <= '0;
      out_q   <= '0;
      en_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      stat_q  <= '0;
      prime_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      oe_q    <= oe_d;
      out_q   <= out_d;
      en_q    <= en_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      stat_q  <= stat_d;
      prime_q <= prime_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rdata  = rdata_q;
  assign gpio_val_o = out_q;
  assign gpio_dir_o = ~oe_q;
  assign irq_o      = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: 8-, 32- and 5-pin
// instances, directed register and pad stimulus.
module tb_gpio_bank;
  import gpio_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] e;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_if b8  ();
  gpio_if b32 ();
  gpio_if b5  ();

  logic [7:0]  pin8  = '0;
  logic [7:0]  val8, dir8;
  logic        irq8;
  logic [31:0] pin32 = '0;
  logic [31:0] val32, dir32;
  logic        irq32;
  logic [4:0]  pin5  = '0;
  logic [4:0]  val5, dir5;
  logic        irq5;

  gpio_bank #(.N_GPIO(8)) u8 (
    .sys_clk_i (clk), .sys_rst_i (rst),
    .bus (b8.slave), .gpio_val_i (pin8),
    .gpio_val_o (val8), .gpio_dir_o (dir8),
    .irq_o (irq8)
  );
  gpio_bank #(.N_GPIO(32)) u32 (
    .sys_clk_i (clk), .sys_rst_i (rst),
    .bus (b32.slave), .gpio_val_i (pin32),
    .gpio_val_o (val32), .gpio_dir_o (dir32),
    .irq_o (irq32)
  );
  gpio_bank #(.N_GPIO(5)) u5 (
    .sys_clk_i (clk), .sys_rst_i (rst),
    .bus (b5.slave), .gpio_val_i (pin5),
    .gpio_val_o (val5), .gpio_dir_o (dir5),
    .irq_o (irq5)
  );

  int total = 0;
  int bad   = 0;
  ent_t q8[$], q32[$], q5[$];
  bit p8 = 0, p32 = 0, p5 = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ent_t t;
    if (p8) chk("rdy8_width", 32'(b8.ready), 0);
    if (b8.ready) begin
      if (q8.size() == 0)
        chk("rdy8_spurious", 32'(b8.ready), 0);
      else begin
        t = q8.pop_front();
        chk($sformatf("rd8@%0h", t.a), b8.rdata, t.e);
      end
    end
    p8 = b8.ready;
  end

  always @(negedge clk) begin
    ent_t t;
    if (p32) chk("rdy32_width", 32'(b32.ready), 0);
    if (b32.ready) begin
      if (q32.size() == 0)
        chk("rdy32_spurious", 32'(b32.ready), 0);
      else begin
        t = q32.pop_front();
        chk($sformatf("rd32@%0h", t.a), b32.rdata, t.e);
      end
    end
    p32 = b32.ready;
  end

  always @(negedge clk) begin
    ent_t t;
    if (p5) chk("rdy5_width", 32'(b5.ready), 0);
    if (b5.ready) begin
      if (q5.size() == 0)
        chk("rdy5_spurious", 32'(b5.ready), 0);
      else begin
        t = q5.pop_front();
        chk($sformatf("rd5@%0h", t.a), b5.rdata, t.e);
      end
    end
    p5 = b5.ready;
  end

  // Called #1 after an edge; returns #1 after the ready cycle.
  task automatic acc(input int u, input bit w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] e);
    ent_t t;
    t.a = a;
    t.e = w ? 32'h0 : e;
    case (u)
      0: begin
        b8.req = 1'b1; b8.we = w;
        b8.addr = a[5:0]; b8.wdata = d;
        q8.push_back(t);
      end
      1: begin
        b32.req = 1'b1; b32.we = w;
        b32.addr = a[5:0]; b32.wdata = d;
        q32.push_back(t);
      end
      default: begin
        b5.req = 1'b1; b5.we = w;
        b5.addr = a[5:0]; b5.wdata = d;
        q5.push_back(t);
      end
    endcase
    @(posedge clk); #1;
    b8.req = 1'b0; b32.req = 1'b0; b5.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int u, input logic [31:0] a,
                    input logic [31:0] d);
    acc(u, 1'b1, a, d, 32'h0);
  endtask

  task automatic rd(input int u, input logic [31:0] a,
                    input logic [31:0] e);
    acc(u, 1'b0, a, 32'h0, e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    b8.req = 0;  b8.we = 0;  b8.addr = '0;  b8.wdata = '0;
    b32.req = 0; b32.we = 0; b32.addr = '0; b32.wdata = '0;
    b5.req = 0;  b5.we = 0;  b5.addr = '0;  b5.wdata = '0;

    cyc(3);
    chk("rst_dir", 32'(dir8), 32'hFF);
    chk("rst_val", 32'(val8), 32'h00);
    chk("rst_irq", 32'(irq8), 32'h0);
    chk("rst_rdy", 32'(b8.ready), 32'h0);
    chk("rst_rdata", b8.rdata, 32'h0);
    rst = 1'b0;

    rd(0, GPIO_OE, 32'h0);
    rd(0, GPIO_OUT, 32'h0);
    rd(0, GPIO_IRQ_STATUS, 32'h0);

    wr(0, GPIO_OE, 32'h0F);
    chk("dir_oe", 32'(dir8), 32'hF0);
    wr(0, GPIO_OUT, 32'hA5);
    chk("val_out", 32'(val8), 32'hA5);
    wr(0, GPIO_SET, 32'h10);
    chk("val_set", 32'(val8), 32'hB5);
    wr(0, GPIO_CLR, 32'h01);
    chk("val_clr", 32'(val8), 32'hB4);
    wr(0, GPIO_TGL, 32'h03);
    chk("val_tgl", 32'(val8), 32'hB7);
    rd(0, GPIO_OUT, 32'hB7);
    rd(0, GPIO_SET, 32'h0);

    wr(0, GPIO_IRQ_RISE, 32'h08);
    wr(0, GPIO_IRQ_EN, 32'h08);
    pin8[3] = 1'b1;
    cyc(1);
    chk("irq_e1", 32'(irq8), 32'h0);
    cyc(1);
    chk("irq_e2", 32'(irq8), 32'h0);
    cyc(1);
    chk("irq_e3", 32'(irq8), 32'h1);
    rd(0, GPIO_IN, 32'h08);
    rd(0, GPIO_IRQ_STATUS, 32'h08);
    wr(0, GPIO_IRQ_STATUS, 32'h08);
    chk("irq_w1c", 32'(irq8), 32'h0);

    wr(0, GPIO_IRQ_RISE, 32'h0C);
    pin8[2] = 1'b1;
    cyc(4);
    rd(0, GPIO_IRQ_STATUS, 32'h04);
    pin8[2] = 1'b0;
    cyc(4);
    pin8[2] = 1'b1;
    cyc(2);
    wr(0, GPIO_IRQ_STATUS, 32'h04);
    rd(0, GPIO_IRQ_STATUS, 32'h04);
    wr(0, GPIO_IRQ_STATUS, 32'h04);
    rd(0, GPIO_IRQ_STATUS, 32'h00);

    rd(0, 32'h3C, 32'h0);
    wr(0, 32'h28, 32'hFF);
    rd(0, GPIO_OE, 32'h0F);

    wr(1, GPIO_OUT, 32'hFFFF_FFFF);
    wr(1, GPIO_TGL, 32'h8000_0001);
    rd(1, GPIO_OUT, 32'h7FFF_FFFE);
    chk("val32", val32, 32'h7FFF_FFFE);
    wr(2, GPIO_OE, 32'hFF);
    rd(2, GPIO_OE, 32'h1F);
    chk("dir5", 32'(dir5), 32'h0);

    pin8 = 8'h81;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    wr(0, GPIO_IRQ_RISE, 32'hFF);
    wr(0, GPIO_IRQ_FALL, 32'h80);
    cyc(4);
    rd(0, GPIO_IRQ_STATUS, 32'h00);
    pin8[7] = 1'b0;
    cyc(4);
    rd(0, GPIO_IRQ_STATUS, 32'h80);
    chk("irq_noen", 32'(irq8), 32'h0);
    wr(0, GPIO_IRQ_EN, 32'h80);
    chk("irq_en", 32'(irq8), 32'h1);

    cyc(3);
    chk("q8_drain", 32'(q8.size()), 32'h0);
    chk("q32_drain", 32'(q32.size()), 32'h0);
    chk("q5_drain", 32'(q5.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
